ibex_pext_simd_mac: RTL and testbench

Parametrised multicycle SIMD multiply-accumulate unit for the P-extension datapath. It executes packed 8-bit and 16-bit dot-product-accumulate ops (SMAQA/UMAQA/KMADA/KMAXDA/KMSDA) on Width-bit operands. A configurable number of shared 17x17 multipliers is iterated over cycles. It sits beside ibex_alu_pext as a successor to its fixed 32-bit multicycle multiplier and supports Width=64 and area/latency trade-off via NumMul.

---
 rtl/ibex_pkg_pext.sv | 33 +++
 rtl/ibex_pext_mac_lane.sv | 52 +++++
 rtl/ibex_pext_simd_mac.sv | 137 +++++++++++++
 tb/tb_ibex_pext_simd_mac.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_pkg_pext.sv
// Shared types and helpers for the P-extension SIMD multiply-accumulate unit.
package ibex_pkg_pext;

  typedef enum logic [2:0] {
    MAC_SMAQA  = 3'd0,
    MAC_UMAQA  = 3'd1,
    MAC_KMADA  = 3'd2,
    MAC_KMAXDA = 3'd3,
    MAC_KMSDA  = 3'd4
  } mac_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } mac_state_e;

  function automatic logic is_byte_op(input mac_op_e op);
    return (op == MAC_SMAQA) || (op == MAC_UMAQA);
  endfunction

  function automatic logic is_sat_op(input mac_op_e op);
    return (op == MAC_KMADA) || (op == MAC_KMAXDA) || (op == MAC_KMSDA);
  endfunction

  // Clamp a 35-bit accumulator to int32; bit 32 of the return flags a clamp.
  function automatic logic [32:0] sat32(input logic signed [34:0] acc);
    if (acc > 35'sh0_7FFF_FFFF) return {1'b1, 32'h7FFF_FFFF};
    if (acc < -35'sh0_8000_0000) return {1'b1, 32'h8000_0000};
    return {1'b0, acc[31:0]};
  endfunction

endpackage

// File: rtl/ibex_pext_mac_lane.sv
// One SIMD MAC lane: picks an element pair from a 32-bit word and multiplies
// them in a single 17x17 signed multiplier (bytes and halves both fit).
module ibex_pext_mac_lane
  import ibex_pkg_pext::*;
(
  input  mac_op_e            i_op,
  input  logic [31:0]        i_a,
  input  logic [31:0]        i_b,
  input  logic [1:0]         i_k,
  output logic signed [33:0] o_prod
);

  logic [7:0]         w_a8, w_b8;
  logic [15:0]        w_a16, w_b16, w_b16x;
  logic signed [16:0] w_x, w_y;

  assign w_a8   = i_a[{i_k, 3'd0} +: 8];
  assign w_b8   = i_b[{i_k, 3'd0} +: 8];
  assign w_a16  = i_a[{i_k[0], 4'd0} +: 16];
  assign w_b16  = i_b[{i_k[0], 4'd0} +: 16];
  assign w_b16x = i_b[{~i_k[0], 4'd0} +: 16];

  always_comb begin
    w_x = '0;
    w_y = '0;
    case (i_op)
      MAC_SMAQA: begin
        w_x = {{9{w_a8[7]}}, w_a8};
        w_y = {{9{w_b8[7]}}, w_b8};
      end
      MAC_UMAQA: begin
        w_x = {9'd0, w_a8};
        w_y = {9'd0, w_b8};
      end
      MAC_KMADA, MAC_KMSDA: begin
        w_x = {w_a16[15], w_a16};
        w_y = {w_b16[15], w_b16};
      end
      MAC_KMAXDA: begin
        w_x = {w_a16[15], w_a16};
        w_y = {w_b16x[15], w_b16x};
      end
      default: begin
        w_x = '0;
        w_y = '0;
      end
    endcase
  end

  assign o_prod = w_x * w_y;

endmodule

// File: rtl/ibex_pext_simd_mac.sv
// Multicycle SIMD dot-product-accumulate unit: NumMul shared lanes iterate
// over all element products, accumulating into one 35-bit register per word.
module ibex_pext_simd_mac
  import ibex_pkg_pext::*;
#(
  parameter int Width  = 32,
  parameter int NumMul = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             kill_i,
  input  logic [2:0]       mac_op_i,
  input  logic [Width-1:0] operand_a_i,
  input  logic [Width-1:0] operand_b_i,
  input  logic [Width-1:0] operand_rd_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [Width-1:0] result_o,
  output logic             ov_o
);

  localparam int NW = Width / 32;
  localparam logic [3:0] LastH = 4'(NW * 2 / NumMul - 1);
  localparam logic [3:0] LastB = 4'(NW * 4 / NumMul - 1);

  mac_state_e         r_state, w_state_next;
  logic [2:0]         r_op;
  logic [Width-1:0]   r_a, r_b, r_result;
  logic               r_ov;
  logic [3:0]         r_cnt;
  logic signed [34:0] r_acc      [NW];
  logic signed [34:0] w_acc_next [NW];
  mac_op_e            w_op;
  logic               w_byte, w_sat_op, w_last, w_accept;
  logic [Width-1:0]   w_result;
  logic [NW-1:0]      w_ov_word;
  logic [2:0]         w_lane_word [NumMul];
  logic signed [33:0] w_prod      [NumMul];

  assign w_op     = mac_op_e'(r_op);
  assign w_byte   = is_byte_op(w_op);
  assign w_sat_op = is_sat_op(w_op);
  assign w_last   = (r_cnt == (w_byte ? LastB : LastH));
  assign w_accept = (r_state == IDLE) && start_i && !kill_i;

  // Lane gi handles global product index g = cnt*NumMul + gi this cycle.
  generate
    for (genvar gi = 0; gi < NumMul; gi++) begin : g_lane
      logic [3:0] w_g;
      logic [1:0] w_k;
      assign w_g = r_cnt * 4'(NumMul) + 4'(gi);
      assign w_lane_word[gi] = w_byte ? {1'b0, w_g[3:2]} : w_g[3:1];
      assign w_k = w_byte ? w_g[1:0] : {1'b0, w_g[0]};

      ibex_pext_mac_lane u_lane (
        .i_op   (w_op),
        .i_a    (r_a[{w_lane_word[gi], 5'd0} +: 32]),
        .i_b    (r_b[{w_lane_word[gi], 5'd0} +: 32]),
        .i_k    (w_k),
        .o_prod (w_prod[gi])
      );
    end
  endgenerate

  always_comb begin
    for (int w = 0; w < NW; w++) begin
      w_acc_next[w] = r_acc[w];
      for (int m = 0; m < NumMul; m++) begin
        if (w_lane_word[m] == 3'(w)) begin
          if (w_op == MAC_KMSDA) w_acc_next[w] = w_acc_next[w] - 35'(w_prod[m]);
          else                   w_acc_next[w] = w_acc_next[w] + 35'(w_prod[m]);
        end
      end
    end
  end

  // Final word values are formed from the last slice's sums so result_o is
  // already registered while valid_o is high in DONE.
  generate
    for (genvar gi = 0; gi < NW; gi++) begin : g_word
      logic [32:0] w_sat;
      assign w_sat = sat32(w_acc_next[gi]);
      assign w_result[gi*32 +: 32] = w_sat_op ? w_sat[31:0] :
                                     (w_byte ? w_acc_next[gi][31:0] : 32'd0);
      assign w_ov_word[gi] = w_sat_op & w_sat[32];
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = MUL;
      MUL: begin
        if (kill_i)      w_state_next = IDLE;
        else if (w_last) w_state_next = DONE;
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= IDLE;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_ov     <= 1'b0;
      for (int w = 0; w < NW; w++) r_acc[w] <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_op  <= mac_op_i;
        r_a   <= operand_a_i;
        r_b   <= operand_b_i;
        r_cnt <= '0;
        for (int w = 0; w < NW; w++) r_acc[w] <= 35'($signed(operand_rd_i[w*32 +: 32]));
      end else if (r_state == MUL && !kill_i) begin
        r_cnt <= r_cnt + 4'd1;
        for (int w = 0; w < NW; w++) r_acc[w] <= w_acc_next[w];
        if (w_last) begin
          r_result <= w_result;
          r_ov     <= |w_ov_word;
        end
      end
    end
  end

  assign ready_o  = (r_state == IDLE);
  assign valid_o  = (r_state == DONE);
  assign result_o = r_result;
  assign ov_o     = r_ov;

endmodule

// File: tb/tb_ibex_pext_simd_mac.sv
// Scoreboard bench for ibex_pext_simd_mac: a 32-bit/1-multiplier instance and a
// 64-bit/2-multiplier instance, checked against a behavioural dot-product model.
module tb_ibex_pext_simd_mac;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        st32 = 0, kl32 = 0, rdy32, vld32, ov32;
  logic [2:0]  op32 = 0;
  logic [31:0] a32 = 0, b32 = 0, rd32 = 0, res32;
  logic        st64 = 0, kl64 = 0, rdy64, vld64, ov64;
  logic [2:0]  op64 = 0;
  logic [63:0] a64 = 0, b64 = 0, rd64 = 0, res64;

  typedef struct {
    logic [63:0] res;
    logic        ov;
    int          cyc;
  } exp_t;

  exp_t        q32[$], q64[$];
  exp_t        e32, e64;
  int          n_chk = 0, n_fail = 0, cyc = 0;
  logic [63:0] last32 = '0;
  logic        last_ov32 = 1'b0;

  ibex_pext_simd_mac #(.Width(32), .NumMul(1)) u_dut32 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(st32), .kill_i(kl32), .mac_op_i(op32),
    .operand_a_i(a32), .operand_b_i(b32), .operand_rd_i(rd32),
    .ready_o(rdy32), .valid_o(vld32), .result_o(res32), .ov_o(ov32)
  );

  ibex_pext_simd_mac #(.Width(64), .NumMul(2)) u_dut64 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(st64), .kill_i(kl64), .mac_op_i(op64),
    .operand_a_i(a64), .operand_b_i(b64), .operand_rd_i(rd64),
    .ready_o(rdy64), .valid_o(vld64), .result_o(res64), .ov_o(ov64)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int nn(input logic [2:0] op, input int nw, input int nm);
    return ((op == 3'd0 || op == 3'd1) ? 4 : 2) * nw / nm;
  endfunction

  function automatic longint el(input logic [63:0] v, input int w, input int sz,
                                input int idx, input bit sgn);
    logic [15:0] h;
    logic [7:0]  by;
    if (sz == 16) begin
      h = v[w*32 + idx*16 +: 16];
      return sgn ? longint'($signed(h)) : longint'(h);
    end
    by = v[w*32 + idx*8 +: 8];
    return sgn ? longint'($signed(by)) : longint'(by);
  endfunction

  // Returns {ov, result}.
  function automatic logic [64:0] model(input logic [2:0] op, input logic [63:0] a,
                                        input logic [63:0] b, input logic [63:0] rd,
                                        input int nw);
    logic [63:0] r;
    logic        ov;
    longint      acc;
    r  = '0;
    ov = 1'b0;
    for (int w = 0; w < nw; w++) begin
      acc = longint'($signed(rd[w*32 +: 32]));
      case (op)
        3'd0: for (int j = 0; j < 4; j++) acc += el(a, w, 8, j, 1) * el(b, w, 8, j, 1);
        3'd1: for (int j = 0; j < 4; j++) acc += el(a, w, 8, j, 0) * el(b, w, 8, j, 0);
        3'd2: acc += el(a, w, 16, 1, 1) * el(b, w, 16, 1, 1) + el(a, w, 16, 0, 1) * el(b, w, 16, 0, 1);
        3'd3: acc += el(a, w, 16, 1, 1) * el(b, w, 16, 0, 1) + el(a, w, 16, 0, 1) * el(b, w, 16, 1, 1);
        3'd4: acc -= el(a, w, 16, 1, 1) * el(b, w, 16, 1, 1) + el(a, w, 16, 0, 1) * el(b, w, 16, 0, 1);
        default: acc = 0;
      endcase
      if (op >= 3'd2 && op <= 3'd4) begin
        if (acc > 64'sh7FFF_FFFF) begin
          acc = 64'sh7FFF_FFFF;
          ov  = 1'b1;
        end else if (acc < -64'sh8000_0000) begin
          acc = -64'sh8000_0000;
          ov  = 1'b1;
        end
      end
      r[w*32 +: 32] = acc[31:0];
    end
    return {ov, r};
  endfunction

  always @(negedge clk) begin
    if (vld32) begin
      if (q32.size() == 0) chk("spurious_valid32", 64'(vld32), 64'd0);
      else begin
        e32 = q32.pop_front();
        chk("res32", 64'(res32), e32.res);
        chk("ov32", 64'(ov32), 64'(e32.ov));
        chk("lat32", 64'(cyc), 64'(e32.cyc));
        last32    = e32.res;
        last_ov32 = e32.ov;
      end
    end
    if (vld64) begin
      if (q64.size() == 0) chk("spurious_valid64", 64'(vld64), 64'd0);
      else begin
        e64 = q64.pop_front();
        chk("res64", res64, e64.res);
        chk("ov64", 64'(ov64), 64'(e64.ov));
        chk("lat64", 64'(cyc), 64'(e64.cyc));
      end
    end
  end

  // Waits for ready, drives one request for one cycle, optionally scoreboards it.
  task automatic launch(input bit w64, input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] rd, input bit push,
                        input logic [63:0] er, input logic eo);
    int   g;
    exp_t e;
    g = 0;
    @(negedge clk);
    while (!(w64 ? rdy64 : rdy32) && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) chk("ready_timeout", 64'd0, 64'd1);
    if (w64) begin
      op64 = op; a64 = a; b64 = b; rd64 = rd; st64 = 1'b1;
    end else begin
      op32 = op; a32 = a[31:0]; b32 = b[31:0]; rd32 = rd[31:0]; st32 = 1'b1;
    end
    if (push) begin
      e.res = er;
      e.ov  = eo;
      e.cyc = cyc + 1 + nn(op, w64 ? 2 : 1, w64 ? 2 : 1);
      if (w64) q64.push_back(e);
      else     q32.push_back(e);
    end
    @(posedge clk);
    #1;
    st32 = 1'b0;
    st64 = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((q32.size() != 0 || q64.size() != 0) && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("drain", 64'(q32.size() + q64.size()), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [64:0] m;
    logic [2:0]  rop;
    logic [63:0] ra, rb, rr;
    int          pushes;
    exp_t        e;

    repeat (3) @(negedge clk);
    chk("rst_ready32", 64'(rdy32), 64'd1);
    chk("rst_valid32", 64'(vld32), 64'd0);
    chk("rst_res32", 64'(res32), 64'd0);
    chk("rst_ov32", 64'(ov32), 64'd0);
    chk("rst_ready64", 64'(rdy64), 64'd1);
    chk("rst_res64", res64, 64'd0);
    rst_n = 1'b1;

    launch(0, 3'd2, 64'h0003_0002, 64'h0005_0004, 64'h10, 1, 64'h27, 1'b0);
    launch(0, 3'd3, 64'h0003_0002, 64'h0005_0004, 64'h10, 1, 64'h26, 1'b0);
    launch(0, 3'd2, 64'h8000_8000, 64'h8000_8000, 64'h7FFF_FFFF, 1, 64'h7FFF_FFFF, 1'b1);
    launch(0, 3'd4, 64'h8000_8000, 64'h8000_8000, 64'h8000_0000, 1, 64'h8000_0000, 1'b1);
    launch(0, 3'd0, 64'hFF02_0304, 64'h0202_0202, 64'h100, 1, 64'h110, 1'b0);
    launch(0, 3'd1, 64'hFF02_0304, 64'h0202_0202, 64'h100, 1, 64'h310, 1'b0);
    launch(0, 3'd6, 64'h1234_5678, 64'h1111_1111, 64'h55, 1, 64'h0, 1'b0);
    launch(1, 3'd2, {32'h0003_0002, 32'h8000_8000}, {32'h0005_0004, 32'h8000_8000},
           {32'h10, 32'h7FFF_FFFF}, 1, 64'h0000_0027_7FFF_FFFF, 1'b1);

    for (int i = 0; i < 16; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = {$urandom, $urandom};
      rb  = {$urandom, $urandom};
      rr  = {$urandom, $urandom};
      m   = model(rop, ra, rb, rr, i[0] ? 2 : 1);
      launch(i[0], rop, ra, rb, rr, 1, m[63:0], m[64]);
    end
    drain();

    // start_i held high: expect an accept only every N+2 = 4 cycles.
    pushes = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (i == 0) begin
        op32 = 3'd2; a32 = 32'h0003_0002; b32 = 32'h0005_0004; rd32 = 32'h10; st32 = 1'b1;
      end
      if (i == 13) st32 = 1'b0;
      else if (rdy32) begin
        e.res = 64'h27; e.ov = 1'b0; e.cyc = cyc + 1 + 2;
        q32.push_back(e);
        pushes++;
      end
    end
    chk("held_accepts", 64'(pushes), 64'd4);
    drain();

    // Kill in the second MUL cycle of an op that would otherwise saturate.
    launch(0, 3'd2, 64'h8000_8000, 64'h8000_8000, 64'h7FFF_FFFF, 0, 64'd0, 1'b0);
    @(posedge clk);
    #1 kl32 = 1'b1;
    @(posedge clk);
    #1 kl32 = 1'b0;
    chk("kill_ready", 64'(rdy32), 64'd1);
    chk("kill_res", 64'(res32), last32);
    chk("kill_ov", 64'(ov32), 64'(last_ov32));
    repeat (5) @(negedge clk);

    // start_i together with kill_i in IDLE is dropped.
    @(negedge clk);
    op32 = 3'd4; a32 = 32'h8000_8000; b32 = 32'h8000_8000; rd32 = 32'h8000_0000;
    st32 = 1'b1; kl32 = 1'b1;
    @(posedge clk);
    #1 st32 = 1'b0; kl32 = 1'b0;
    chk("startkill_ready", 64'(rdy32), 64'd1);
    repeat (5) @(negedge clk);

    // Reset mid-MUL returns outputs to reset values.
    launch(0, 3'd0, 64'hFF02_0304, 64'h0202_0202, 64'h100, 0, 64'd0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_ready", 64'(rdy32), 64'd1);
    chk("midrst_valid", 64'(vld32), 64'd0);
    chk("midrst_res", 64'(res32), 64'd0);
    chk("midrst_ov", 64'(ov32), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
